// File: rtl/fp_multiplier_pipe_if.sv
// Operand/result bus of the pipelined floating-point multiplier.
interface fp_multiplier_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         en;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic [W-1:0] res;
    logic         val;
    logic         overflow;
    logic         underflow;
    logic         invalid;

    modport master (
        output en, num1, num2,
        input  res, val, overflow, underflow, invalid
    );

    modport slave (
        input  en, num1, num2,
        output res, val, overflow, underflow, invalid
    );
endinterface

// File: rtl/fp_multiplier_pipe.sv
// Three-stage IEEE-754-style multiplier: unpack, significand product,
// normalise/round-to-nearest-even/pack. Subnormals are flushed to zero on
// both input and output.
module fp_multiplier_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic                 clk,
    input logic                 rst,
    fp_multiplier_pipe_if.slave bus
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned EW = EXP_W + 2;

    localparam logic [EXP_W-1:0]        EXP_ONES   = '1;
    localparam logic [EXP_W-1:0]        EXP_ZERO   = '0;
    localparam logic [MAN_W-1:0]        FRAC_ZERO  = '0;
    localparam logic [MAN_W-1:0]        QNAN_FRAC  = {1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0]    BIAS       = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0]    E_MAX      = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]    E_ZERO     = '0;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_e;

    // ---------------- S1: unpack and classify ----------------
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [EW-1:0] e_sum_c;
    special_e           sp_c;

    assign a_sign = bus.num1[W-1];
    assign b_sign = bus.num2[W-1];
    assign a_exp  = bus.num1[W-2 -: EXP_W];
    assign b_exp  = bus.num2[W-2 -: EXP_W];
    assign a_frac = bus.num1[MAN_W-1:0];
    assign b_frac = bus.num2[MAN_W-1:0];

    assign a_zero = (a_exp == EXP_ZERO);
    assign b_zero = (b_exp == EXP_ZERO);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == FRAC_ZERO);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == FRAC_ZERO);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != FRAC_ZERO);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != FRAC_ZERO);

    assign e_sum_c = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;

    // Special-case priority: invalid beats Inf beats zero.
    always_comb begin
        sp_c = SP_NONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            sp_c = SP_NAN;
        end else if (a_inf || b_inf) begin
            sp_c = SP_INF;
        end else if (a_zero || b_zero) begin
            sp_c = SP_ZERO;
        end
    end

    logic                 s1_v, s1_sign;
    special_e             s1_sp;
    logic signed [EW-1:0] s1_exp;
    logic [SW-1:0]        s1_siga, s1_sigb;

    // Capture operands with hidden bit restored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_sp   <= SP_NONE;
            s1_exp  <= '0;
            s1_siga <= '0;
            s1_sigb <= '0;
        end else begin
            s1_v    <= bus.en;
            s1_sign <= a_sign ^ b_sign;
            s1_sp   <= sp_c;
            s1_exp  <= e_sum_c;
            s1_siga <= {1'b1, a_frac};
            s1_sigb <= {1'b1, b_frac};
        end
    end

    // ---------------- S2: significand product ----------------
    logic                 s2_v, s2_sign;
    special_e             s2_sp;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;

    // Full-width unsigned significand multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_sign <= 1'b0;
            s2_sp   <= SP_NONE;
            s2_exp  <= '0;
            s2_prod <= '0;
        end else begin
            s2_v    <= s1_v;
            s2_sign <= s1_sign;
            s2_sp   <= s1_sp;
            s2_exp  <= s1_exp;
            s2_prod <= PW'(s1_siga) * PW'(s1_sigb);
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [PW-2:0]        norm_c;
    logic [MAN_W-1:0]     frac_c;
    logic                 guard_c, sticky_c, round_up_c;
    logic [SW-1:0]        frac_r_c;
    logic signed [EW-1:0] exp_n_c;
    logic [W-1:0]         res_c;
    logic                 ovf_c, unf_c, inv_c;

    // Product is in [1,4): drop the leading one, left-aligning when below 2.
    assign norm_c     = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    assign frac_c     = norm_c[PW-2 -: MAN_W];
    assign guard_c    = norm_c[PW-2-MAN_W];
    assign sticky_c   = |norm_c[PW-3-MAN_W:0];
    assign round_up_c = guard_c & (sticky_c | frac_c[0]);
    assign frac_r_c   = {1'b0, frac_c} + SW'(round_up_c);
    assign exp_n_c    = s2_exp + EW'(s2_prod[PW-1]) + EW'(frac_r_c[MAN_W]);

    // Select special result or range-checked normal result.
    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        unf_c = 1'b0;
        inv_c = 1'b0;
        case (s2_sp)
            SP_NAN: begin
                res_c = {1'b0, EXP_ONES, QNAN_FRAC};
                inv_c = 1'b1;
            end
            SP_INF:  res_c = {s2_sign, EXP_ONES, FRAC_ZERO};
            SP_ZERO: res_c = {s2_sign, EXP_ZERO, FRAC_ZERO};
            default: begin
                if (exp_n_c >= E_MAX) begin
                    res_c = {s2_sign, EXP_ONES, FRAC_ZERO};
                    ovf_c = 1'b1;
                end else if (exp_n_c <= E_ZERO) begin
                    res_c = {s2_sign, EXP_ZERO, FRAC_ZERO};
                    unf_c = 1'b1;
                end else begin
                    res_c = {s2_sign, exp_n_c[EXP_W-1:0], frac_r_c[MAN_W-1:0]};
                end
            end
        endcase
    end

    logic         val_q, ovf_q, unf_q, inv_q;
    logic [W-1:0] res_q;

    // Output register; result and flags hold across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            val_q <= s2_v;
            if (s2_v) begin
                res_q <= res_c;
                ovf_q <= ovf_c;
                unf_q <= unf_c;
                inv_q <= inv_c;
            end
        end
    end

    assign bus.val       = val_q;
    assign bus.res       = res_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.invalid   = inv_q;
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed and model-checked bench for fp_multiplier_pipe (single and half precision).
module tb_fp_multiplier_pipe;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fp_multiplier_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
    fp_multiplier_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

    fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    fp_multiplier_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    logic        h_en  [1000];
    logic [15:0] h_res [1000];
    logic [2:0]  h_flg [1000];

    // Independent reference: integer product, leading-one search, remainder-based RNE.
    task automatic model(input int ew, input int mw, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic [2:0] f);
        longint      emax, bias, ea, eb, ex, shift;
        logic [63:0] emax_u, fmask, fa, fb, p, q, rem, half, sgn;
        logic        na, nb, ia, ib, za, zb;
        int          k;
        emax_u = (64'd1 << ew) - 64'd1;
        emax   = longint'(emax_u);
        bias   = (longint'(1) << (ew - 1)) - 1;
        fmask  = (64'd1 << mw) - 64'd1;
        sgn    = 64'(a[ew+mw] ^ b[ew+mw]) << (ew + mw);
        ea = longint'((a >> mw) & emax_u);
        eb = longint'((b >> mw) & emax_u);
        fa = a & fmask;
        fb = b & fmask;
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
        f = 3'b000;
        r = 64'd0;
        if (na || nb || (ia && zb) || (za && ib)) begin
            r = (emax_u << mw) | (64'd1 << (mw - 1));
            f = 3'b001;
        end else if (ia || ib) begin
            r = sgn | (emax_u << mw);
        end else if (za || zb) begin
            r = sgn;
        end else begin
            p = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
            k = 0;
            for (int i = 0; i < 64; i++) if (p[i]) k = i;
            shift = longint'(k - mw);
            q    = p >> shift;
            rem  = p & ((64'd1 << shift) - 64'd1);
            half = 64'd1 << (shift - 1);
            ex   = ea + eb - bias + longint'(k - 2 * mw);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << (mw + 1))) begin
                q  = q >> 1;
                ex = ex + 1;
            end
            if (ex >= emax) begin
                r = sgn | (emax_u << mw);
                f = 3'b100;
            end else if (ex <= 0) begin
                r = sgn;
                f = 3'b010;
            end else begin
                r = sgn | (64'(ex) << mw) | (q & fmask);
            end
        end
    endtask

    // Drive one cycle on the single-precision DUT and sample just after the edge.
    task automatic cycle32(input logic e, input logic [31:0] a, input logic [31:0] b,
                           output logic v, output logic [31:0] r, output logic [2:0] f);
        bus32.en   = e;
        bus32.num1 = a;
        bus32.num2 = b;
        @(posedge clk);
        #1;
        v = bus32.val;
        r = bus32.res;
        f = {bus32.overflow, bus32.underflow, bus32.invalid};
    endtask

    task automatic cycle16(input logic e, input logic [15:0] a, input logic [15:0] b,
                           output logic v, output logic [15:0] r, output logic [2:0] f);
        bus16.en   = e;
        bus16.num1 = a;
        bus16.num2 = b;
        @(posedge clk);
        #1;
        v = bus16.val;
        r = bus16.res;
        f = {bus16.overflow, bus16.underflow, bus16.invalid};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus32.en = 1'b0; bus32.num1 = '0; bus32.num2 = '0;
        bus16.en = 1'b0; bus16.num1 = '0; bus16.num2 = '0;
        #1 rst = 1'b1;
        #10;
        checks++; if (bus32.val !== 1'b0) begin errors++; $display("FAIL reset_val32: got %b expected 0", bus32.val); end
        checks++; if (bus32.res !== 32'h0) begin errors++; $display("FAIL reset_res32: got %h expected 00000000", bus32.res); end
        checks++; if (bus32.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf32: got %b expected 0", bus32.overflow); end
        checks++; if (bus32.underflow !== 1'b0) begin errors++; $display("FAIL reset_unf32: got %b expected 0", bus32.underflow); end
        checks++; if (bus32.invalid !== 1'b0) begin errors++; $display("FAIL reset_inv32: got %b expected 0", bus32.invalid); end
        checks++; if (bus16.val !== 1'b0) begin errors++; $display("FAIL reset_val16: got %b expected 0", bus16.val); end
        checks++; if (bus16.res !== 16'h0) begin errors++; $display("FAIL reset_res16: got %h expected 0000", bus16.res); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic v; logic [31:0] r; logic [2:0] f;
        for (int c = 0; c < 6; c++) begin
            cycle32(c == 0, 32'h3FC00000, 32'h40000000, v, r, f);
            checks++;
            if (v !== (c == 2)) begin errors++; $display("FAIL single_val c=%0d: got %b expected %b", c, v, c == 2); end
            if (c == 2) begin
                checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL single_res: got %h expected 40400000", r); end
                checks++; if (f !== 3'b000) begin errors++; $display("FAIL single_flags: got %b expected 000", f); end
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] ta [4] = '{32'h3F800001, 32'h3F800800, 32'h3F800001, 32'h3FFFFFFF};
        logic [31:0] tb [4] = '{32'h3F800001, 32'h3F800800, 32'h3FC00000, 32'h3F800001};
        logic [31:0] te [4] = '{32'h3F800002, 32'h3F801000, 32'h3FC00002, 32'h40000000};
        logic v, ev; logic [31:0] r; logic [2:0] f; int idx;
        for (int c = 0; c < 7; c++) begin
            idx = (c < 4) ? c : 0;
            cycle32(c < 4, ta[idx], tb[idx], v, r, f);
            ev = (c >= 2) && (c < 6);
            checks++;
            if (v !== ev) begin errors++; $display("FAIL round_val c=%0d: got %b expected %b", c, v, ev); end
            if (ev) begin
                checks++; if (r !== te[c-2]) begin errors++; $display("FAIL round_res%0d: got %h expected %h", c - 2, r, te[c-2]); end
                checks++; if (f !== 3'b000) begin errors++; $display("FAIL round_flags%0d: got %b expected 000", c - 2, f); end
            end
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] ta [8] = '{32'h7F000000, 32'h00800000, 32'hFF800000, 32'hFF800000,
                                32'h7FC00001, 32'h80000000, 32'h00400000, 32'h7F7FFFFF};
        logic [31:0] tb [8] = '{32'h40000000, 32'h3F000000, 32'h00000000, 32'h40000000,
                                32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        logic [31:0] te [8] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
                                32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7F7FFFFF};
        logic [2:0]  tf [8] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
        logic v, ev; logic [31:0] r; logic [2:0] f; int idx;
        for (int c = 0; c < 11; c++) begin
            idx = (c < 8) ? c : 0;
            cycle32(c < 8, ta[idx], tb[idx], v, r, f);
            ev = (c >= 2) && (c < 10);
            checks++;
            if (v !== ev) begin errors++; $display("FAIL exc_val c=%0d: got %b expected %b", c, v, ev); end
            if (ev) begin
                checks++; if (r !== te[c-2]) begin errors++; $display("FAIL exc_res%0d: got %h expected %h", c - 2, r, te[c-2]); end
                checks++; if (f !== tf[c-2]) begin errors++; $display("FAIL exc_flags%0d: got %b expected %b", c - 2, f, tf[c-2]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] ta  [8] = '{32'h3F800000, 32'hC0400000, 32'h3F000000, 32'h41200000,
                                 32'h7F7FFFFF, 32'h3F800001, 32'h00000000, 32'h42F60000};
        logic [31:0] tb  [8] = '{32'h3F800000, 32'h40A00000, 32'h3F000000, 32'h3DCCCCCD,
                                 32'h40000000, 32'h3FC00000, 32'h7F800000, 32'hC1100000};
        logic [31:0] er [8]; logic [2:0] ef [8];
        logic [63:0] mr; logic [2:0] mf;
        logic v, ev; logic [31:0] r; logic [2:0] f; int idx;
        for (int i = 0; i < 8; i++) begin
            model(8, 23, {32'h0, ta[i]}, {32'h0, tb[i]}, mr, mf);
            er[i] = mr[31:0];
            ef[i] = mf;
        end
        for (int c = 0; c < 11; c++) begin
            idx = (c < 8) ? c : 0;
            cycle32((c < 8) ? pat[idx] : 1'b0, ta[idx], tb[idx], v, r, f);
            ev = (c >= 2 && c < 10) ? pat[c-2] : 1'b0;
            checks++;
            if (v !== ev) begin errors++; $display("FAIL stream_val c=%0d: got %b expected %b", c, v, ev); end
            if (ev) begin
                checks++; if (r !== er[c-2]) begin errors++; $display("FAIL stream_res%0d: got %h expected %h", c - 2, r, er[c-2]); end
                checks++; if (f !== ef[c-2]) begin errors++; $display("FAIL stream_flags%0d: got %b expected %b", c - 2, f, ef[c-2]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic v; logic [31:0] r; logic [2:0] f;
        cycle32(1'b1, 32'h40000000, 32'h40000000, v, r, f);
        cycle32(1'b1, 32'h40400000, 32'h40000000, v, r, f);
        cycle32(1'b1, 32'h7F000000, 32'h40000000, v, r, f);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus32.val !== 1'b0) begin errors++; $display("FAIL midrst_val: got %b expected 0", bus32.val); end
        checks++; if (bus32.res !== 32'h0) begin errors++; $display("FAIL midrst_res: got %h expected 00000000", bus32.res); end
        checks++;
        if ({bus32.overflow, bus32.underflow, bus32.invalid} !== 3'b000) begin
            errors++; $display("FAIL midrst_flags: got %b expected 000", {bus32.overflow, bus32.underflow, bus32.invalid});
        end
        bus32.en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle32(c == 0, 32'h3FC00000, 32'h40000000, v, r, f);
            checks++;
            if (v !== (c == 2)) begin errors++; $display("FAIL postrst_val c=%0d: got %b expected %b", c, v, c == 2); end
            if (c == 2) begin
                checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL postrst_res: got %h expected 40400000", r); end
            end
        end
    endtask

    task automatic test_half();
        logic v, ev, e; logic [15:0] r, a, b; logic [2:0] f; logic [63:0] mr; logic [2:0] mf;
        for (int c = 0; c < 6; c++) begin
            cycle16(c == 0, 16'h3C00, 16'h4000, v, r, f);
            checks++;
            if (v !== (c == 2)) begin errors++; $display("FAIL half_val c=%0d: got %b expected %b", c, v, c == 2); end
            if (c == 2) begin
                checks++; if (r !== 16'h4000) begin errors++; $display("FAIL half_res: got %h expected 4000", r); end
                checks++; if (f !== 3'b000) begin errors++; $display("FAIL half_flags: got %b expected 000", f); end
            end
        end
        for (int c = 0; c < 1003; c++) begin
            e = 1'b0; a = '0; b = '0;
            if (c < 1000) begin
                e = ($urandom_range(0, 3) != 0);
                a = 16'($urandom);
                b = 16'($urandom);
                model(5, 10, {48'h0, a}, {48'h0, b}, mr, mf);
                h_en[c]  = e;
                h_res[c] = mr[15:0];
                h_flg[c] = mf;
            end
            cycle16(e, a, b, v, r, f);
            ev = (c >= 2 && c < 1002) ? h_en[c-2] : 1'b0;
            checks++;
            if (v !== ev) begin errors++; $display("FAIL rnd_val c=%0d: got %b expected %b", c, v, ev); end
            if (ev) begin
                checks++; if (r !== h_res[c-2]) begin errors++; $display("FAIL rnd_res%0d: got %h expected %h", c - 2, r, h_res[c-2]); end
                checks++; if (f !== h_flg[c-2]) begin errors++; $display("FAIL rnd_flags%0d: got %b expected %b", c - 2, f, h_flg[c-2]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_exceptions();
        test_back_to_back();
        test_reset_midflight();
        test_half();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
